// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the per-core run controller.
package core_run_ctrl_pkg;

    // Per-core run state, exported on state_o (3 bits per core).
    typedef enum logic [2:0] {
        RESET = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        IDLE  = 3'd3,
        WAKE  = 3'd4,
        HALT  = 3'd5
    } run_state_t;

    // Width of the per-core WAKE down-counter (WAKE_DELAY up to 16).
    localparam int WAKE_CNT_W = 4;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Bundle between SoC clock/reset/interrupt logic and the per-core run controller.
interface core_run_ctrl_if #(
    parameter int NUM_CORES = 2
);
    logic [NUM_CORES-1:0]   idle_req_i;
    logic [NUM_CORES-1:0]   continue_idle_i;
    logic [NUM_CORES-1:0]   halt_req_i;
    logic [NUM_CORES-1:0]   icache_busy_i;
    logic [NUM_CORES-1:0]   core_rst_o;
    logic [NUM_CORES-1:0]   icache_valid_o;
    logic [3*NUM_CORES-1:0] state_o;
    logic                   all_idle_o;

    // SoC side: drives requests, observes core control.
    modport master (
        output idle_req_i, continue_idle_i, halt_req_i, icache_busy_i,
        input  core_rst_o, icache_valid_o, state_o, all_idle_o
    );

    // Controller side.
    modport slave (
        input  idle_req_i, continue_idle_i, halt_req_i, icache_busy_i,
        output core_rst_o, icache_valid_o, state_o, all_idle_o
    );
endinterface

// File: rtl/core_run_fsm.sv
// Single-core run FSM: reset release, idle drain, timed wake, debug halt.
module core_run_fsm
    import core_run_ctrl_pkg::*;
#(
    parameter int WAKE_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rel,
    input  logic       i_idle,
    input  logic       i_cont,
    input  logic       i_halt,
    input  logic       i_busy,
    output logic       o_core_rst,
    output logic       o_valid,
    output run_state_t o_state
);
    // WAKE is entered with this value and leaves when it has counted down to 0.
    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_DELAY - 1);

    run_state_t              r_state;
    run_state_t              r_resume;
    logic                    r_wlat;
    logic [WAKE_CNT_W-1:0]   r_wcnt;
    logic                    r_core_rst;
    logic                    r_valid;

    assign o_core_rst = r_core_rst;
    assign o_valid    = r_valid;
    assign o_state    = r_state;

    // State, wake latch, wake counter, resume state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RESET;
            r_resume   <= RUN;
            r_wlat     <= 1'b0;
            r_wcnt     <= '0;
            r_core_rst <= 1'b1;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                RESET: begin
                    // Fetch stays off for the first RUN cycle after release.
                    if (i_rel) begin
                        r_state    <= RUN;
                        r_core_rst <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        // A coincident idle is remembered as the resume target.
                        r_state  <= HALT;
                        r_resume <= i_idle ? IDLE : RUN;
                        r_valid  <= 1'b0;
                    end else if (i_idle) begin
                        r_state <= DRAIN;
                        r_wlat  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (i_halt) begin
                        r_state  <= HALT;
                        r_resume <= IDLE;
                        r_wlat   <= 1'b0;
                    end else if (!i_busy) begin
                        // A wake seen during the drain skips IDLE entirely.
                        r_wlat <= 1'b0;
                        if (r_wlat || i_cont) begin
                            r_state <= WAKE;
                            r_wcnt  <= WAKE_LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (i_cont) begin
                        r_wlat <= 1'b1;
                    end
                end
                IDLE: begin
                    if (i_halt) begin
                        r_state  <= HALT;
                        r_resume <= IDLE;
                    end else if (i_cont) begin
                        r_state <= WAKE;
                        r_wcnt  <= WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (i_halt) begin
                        r_state  <= HALT;
                        r_resume <= RUN;
                    end else if (r_wcnt == '0) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - WAKE_CNT_W'(1);
                    end
                end
                HALT: begin
                    if (!i_halt) begin
                        r_state <= r_resume;
                        r_valid <= (r_resume == RUN);
                    end
                end
                default: begin
                    r_state <= RESET;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Per-core run controller: staggered reset release and all-idle reduction
// around NUM_CORES independent run FSMs.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int NUM_CORES   = 2,
    parameter int RST_STAGGER = 4,
    parameter int WAKE_DELAY  = 3,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    core_run_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_CORES * RST_STAGGER);

    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_CORES-1:0] w_in_idle;
    logic                 r_all_idle;

    assign bus.all_idle_o = r_all_idle;

    // Saturating stagger counter, restarts from 0 on every reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                r_cnt <= '0;
        else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        logic       w_rel;
        run_state_t w_state;

        // Fires on the update that moves the counter to (k+1)*RST_STAGGER.
        assign w_rel = (r_cnt == CNT_W'((k + 1) * RST_STAGGER - 1));

        core_run_fsm #(
            .WAKE_DELAY (WAKE_DELAY)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .i_rel      (w_rel),
            .i_idle     (bus.idle_req_i[k]),
            .i_cont     (bus.continue_idle_i[k]),
            .i_halt     (bus.halt_req_i[k]),
            .i_busy     (bus.icache_busy_i[k]),
            .o_core_rst (bus.core_rst_o[k]),
            .o_valid    (bus.icache_valid_o[k]),
            .o_state    (w_state)
        );

        assign bus.state_o[3*k +: 3] = w_state;
        assign w_in_idle[k]          = (w_state == IDLE) || (w_state == HALT);
    end

    // Registered AND of per-core quiescence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_all_idle <= 1'b0;
        else      r_all_idle <= &w_in_idle;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Parametrised per-core run controller for multi-core builds of the CPU top level.
- Replaces the hard-wired "fetch always valid" tie-off and the single shared continue_idle wake line with per-core state machines.
- Provides staggered reset release, IDLE entry with fetch drain, timed wake, and debug halt for NUM_CORES cores.
- Sits between the SoC clock/reset/interrupt logic and each core's frontend, backend and icache valid input.

Parameters:
- NUM_CORES, 2, number of controlled cores (1..8)
- RST_STAGGER, 4, cycles between successive per-core reset releases (>=1)
- WAKE_DELAY, 3, cycles spent in WAKE before fetch resumes (>=1)
- CNT_W, 8, width of the stagger counter; must hold NUM_CORES*RST_STAGGER

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- idle_req_i  in  NUM_CORES  core k backend committed an IDLE instruction (1-cycle pulse)
- continue_idle_i  in  NUM_CORES  wake event for core k (level or pulse)
- halt_req_i  in  NUM_CORES  debug halt request, level
- icache_busy_i  in  NUM_CORES  core k icache has an outstanding fetch
- core_rst_o  out  NUM_CORES  synchronous active-high reset to core k
- icache_valid_o  out  NUM_CORES  fetch enable to core k icache
- state_o  out  3*NUM_CORES  run_state_t of core k, packed with core 0 in the LSBs
- all_idle_o  out  1  every core in IDLE or HALT

Behaviour:
Reset values (while rst=0):
- core_rst_o = all 1; icache_valid_o = 0; state_o = RESET for every core; all_idle_o = 0.
- Stagger counter = 0.

Stagger counter:
- After rst rises, a saturating CNT_W counter increments once per cycle.
- Core k leaves RESET on the cycle the counter equals (k+1)*RST_STAGGER.
- core_rst_o[k] falls in that same registered update.
- Counter saturates at NUM_CORES*RST_STAGGER.

States per core (run_state_t):
- RESET=0, RUN=1, DRAIN=2, IDLE=3, WAKE=4, HALT=5.

Transitions (priority order: halt > idle > wake):
- RESET -> RUN: stagger condition met; icache_valid_o[k]=1 from the next cycle.
- RUN -> HALT: halt_req_i[k]=1.
- RUN -> DRAIN: idle_req_i[k]=1. icache_valid_o[k] drops in the same registered update (1-cycle latency from the pulse).
- DRAIN -> IDLE: icache_busy_i[k]=0. If busy is already 0 on entry, DRAIN lasts exactly 1 cycle.
- IDLE -> WAKE: continue_idle_i[k]=1. A wake pulse that arrives while in DRAIN is latched and is consumed on IDLE entry, so IDLE lasts 0 cycles and the core goes straight to WAKE.
- WAKE -> RUN: after WAKE_DELAY cycles, counted by a per-core 4-bit down-counter. icache_valid_o[k]=1 on RUN entry.
- Any of DRAIN/IDLE/WAKE -> HALT: halt_req_i[k]=1. A latched wake is cleared on HALT entry.
- HALT -> previous resume state: halt_req_i[k]=0. The resume state is RUN if halted from RUN or WAKE, IDLE if halted from DRAIN or IDLE.
- Halt raised out of DRAIN while icache_busy_i[k]=1: HALT is still entered and valid stays 0.

Rules:
- icache_valid_o[k]=1 only in RUN.
- idle_req_i in any state other than RUN is ignored.
- Simultaneous idle_req_i and halt_req_i in RUN -> HALT with resume state IDLE; the idle is not lost.
- all_idle_o is registered (1-cycle latency). It is the AND over cores of (state in {IDLE, HALT}).
- Asserting rst mid-operation forces every output to its reset value immediately, asynchronously. The stagger sequence restarts after release.
- Every output is registered; there are no combinational input-to-output paths.

Decomposition:
Shared package (core_ctrl_types, or the existing pipeline_types package):
- typedef enum logic [2:0] run_state_t.
- Localparam for the wake counter width.

Sub-module core_run_fsm:
- Single-core FSM, containing the wake latch, the wake down-counter and the resume-state register.
- Inputs: the release pulse from the top, idle, continue, halt, busy.

Top core_run_ctrl:
- Owns the stagger counter and the all_idle reduction.
- Instantiates core_run_fsm NUM_CORES times with a generate loop.

Test Plan (defaults unless noted):
- Stagger: rst released at cycle 0 -> core_rst_o[0] falls at cycle 4, core_rst_o[1] at cycle 8; icache_valid_o[0] rises at cycle 5.
- Idle and drain: core 0 in RUN, idle_req_i[0] pulse at T with icache_busy_i[0]=1 for 3 cycles -> valid=0 from T+1; DRAIN until busy falls; IDLE one cycle after busy falls; all_idle_o still 0 while core 1 is in RUN.
- Wake: from IDLE, continue_idle_i[0] pulse at T -> WAKE at T+1, RUN at T+4, icache_valid_o[0]=1 at T+4.
- Early wake: continue_idle_i[0] pulse while in DRAIN -> IDLE skipped; WAKE on the cycle after busy falls.
- Halt priority: idle_req_i[1] and halt_req_i[1] together in RUN -> HALT; halt dropped -> IDLE, not RUN. With core 0 idle, all_idle_o=1 throughout.
- Async reset mid-WAKE: rst low between clock edges -> all outputs return to reset values before the next edge; the sequence restarts cleanly after release.
